pwm_monitor: RTL

PWM_MONITOR -- requirements
Module: pwm_monitor

---
 rtl/pwm_monitor_pkg.sv | 21 ++
 rtl/pwm_monitor_ch.sv | 164 ++++++++++++++++
 rtl/pwm_monitor.sv | 82 ++++++++
 3 files changed

// File: rtl/pwm_monitor_pkg.sv
// pwm_monitor_pkg
// Shared types and default constants for the PWM monitor.
//   ch_state_t           : per-channel monitor state
//   PWM_CNT_W_DEF        : default counter / expected-value width
//   PWM_MIN_PULSES_DEF   : default number of consecutive good periods to pass
//   PWM_TIMEOUT_DEF      : default rising-edge timeout (timeout build only)
package pwm_monitor_pkg;

  localparam int unsigned PWM_CNT_W_DEF      = 17;
  localparam int unsigned PWM_MIN_PULSES_DEF = 3;
  localparam int unsigned PWM_TIMEOUT_DEF    = 65535;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_ARM,
    CH_MEASURE,
    CH_PASS,
    CH_FAIL
  } ch_state_t;

endpackage

// File: rtl/pwm_monitor_ch.sv
// pwm_monitor_ch
// Single-channel PWM checker: synchronizes one asynchronous PWM input,
// measures period and high time between synchronized rising edges and
// compares them against the expected values within +/- tol.
// Optional feature macro: PWM_MONITOR_TIMEOUT_EN (rising-edge timeout -> FAIL).
// Ports:
//   HCLK, HRESETn          : clock, synchronous active-low reset
//   pwm                    : asynchronous PWM input
//   start                  : single-cycle arm pulse
//   exp_period/exp_high/tol: expected values and allowed deviation
//   done/pass/fail         : status (sticky until start or reset)
//   meas_period/meas_high  : last captured measurements
module pwm_monitor_ch
  import pwm_monitor_pkg::*;
#(
  parameter int unsigned CNT_W      = PWM_CNT_W_DEF,
  parameter int unsigned MIN_PULSES = PWM_MIN_PULSES_DEF,
  parameter int unsigned TIMEOUT    = PWM_TIMEOUT_DEF
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             pwm,
  input  logic             start,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] tol,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high
);

  localparam int unsigned MATCH_W = $clog2(MIN_PULSES + 1);

  if (MIN_PULSES < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("pwm_monitor_ch: MIN_PULSES and TIMEOUT must be >= 1");
  end

  ch_state_t          state_q, state_nxt;
  logic               sync1_q, sync2_q, sync_prev_q;
  logic               rise;
  logic [CNT_W-1:0]   period_cnt_q, high_cnt_q;
  logic [MATCH_W-1:0] match_cnt_q;
  logic               cap_ok, last_match;

`ifdef PWM_MONITOR_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_expire;
`endif

  // |a - b| <= t evaluated one bit wider so the difference never wraps.
  function automatic logic in_tol(input logic [CNT_W-1:0] a,
                                  input logic [CNT_W-1:0] b,
                                  input logic [CNT_W-1:0] t);
    logic [CNT_W:0] diff;
    if (a >= b) diff = {1'b0, a} - {1'b0, b};
    else        diff = {1'b0, b} - {1'b0, a};
    return diff <= {1'b0, t};
  endfunction

  assign rise = sync2_q & ~sync_prev_q;

  // A saturated counter means the true value is unknown, so it never matches.
  assign cap_ok = in_tol(period_cnt_q, exp_period, tol) &&
                  in_tol(high_cnt_q, exp_high, tol) &&
                  (period_cnt_q != '1) && (high_cnt_q != '1);

  assign last_match = (match_cnt_q == MATCH_W'(MIN_PULSES - 1));

`ifdef PWM_MONITOR_TIMEOUT_EN
  assign to_expire = !rise && (to_cnt_q == TO_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state_q <= CH_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (start) begin
      state_nxt = CH_ARM;
    end else begin
      unique case (state_q)
        CH_IDLE: state_nxt = CH_IDLE;
        CH_ARM: begin
          if (rise) state_nxt = CH_MEASURE;
`ifdef PWM_MONITOR_TIMEOUT_EN
          else if (to_expire) state_nxt = CH_FAIL;
`endif
        end
        CH_MEASURE: begin
          if (rise) begin
            if (!cap_ok)         state_nxt = CH_FAIL;
            else if (last_match) state_nxt = CH_PASS;
          end
`ifdef PWM_MONITOR_TIMEOUT_EN
          else if (to_expire) state_nxt = CH_FAIL;
`endif
        end
        CH_PASS: state_nxt = CH_PASS;
        CH_FAIL: state_nxt = CH_FAIL;
        default: state_nxt = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync_prev_q  <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      match_cnt_q  <= '0;
      meas_period  <= '0;
      meas_high    <= '0;
`ifdef PWM_MONITOR_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      sync1_q     <= pwm;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      if (start) begin
        period_cnt_q <= '0;
        high_cnt_q   <= '0;
        match_cnt_q  <= '0;
        meas_period  <= '0;
        meas_high    <= '0;
`ifdef PWM_MONITOR_TIMEOUT_EN
        to_cnt_q     <= '0;
`endif
      end else if (state_q == CH_ARM || state_q == CH_MEASURE) begin
        if (rise) begin
          // The edge cycle itself is the first cycle of the new period.
          period_cnt_q <= CNT_W'(1);
          high_cnt_q   <= CNT_W'(1);
          if (state_q == CH_MEASURE) begin
            meas_period <= period_cnt_q;
            meas_high   <= high_cnt_q;
            if (cap_ok) match_cnt_q <= match_cnt_q + MATCH_W'(1);
          end
`ifdef PWM_MONITOR_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end else begin
          if (period_cnt_q != '1) period_cnt_q <= period_cnt_q + CNT_W'(1);
          if (sync2_q && high_cnt_q != '1) high_cnt_q <= high_cnt_q + CNT_W'(1);
`ifdef PWM_MONITOR_TIMEOUT_EN
          to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
        end
      end
    end
  end

  assign done = (state_q == CH_PASS) || (state_q == CH_FAIL);
  assign pass = (state_q == CH_PASS);
  assign fail = (state_q == CH_FAIL);

endmodule

// File: rtl/pwm_monitor.sv
// pwm_monitor
// Multi-channel PWM period / duty checker. One pwm_monitor_ch per channel;
// this level provides the readback mux and the all_pass summary.
// Optional feature macro: PWM_MONITOR_TIMEOUT_EN (rising-edge timeout -> FAIL).
// Ports:
//   HCLK, HRESETn           : clock, synchronous active-low reset
//   pwm[NUM_CH]             : asynchronous PWM inputs
//   start                   : single-cycle pulse arming all channels
//   exp_period/exp_high/tol : expected values, common to all channels
//   ch_sel                  : channel selected for measurement readback
//   done/pass/fail[NUM_CH]  : per-channel status
//   all_pass                : AND of all pass bits
//   meas_period/meas_high   : last captures of channel ch_sel
module pwm_monitor
  import pwm_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = PWM_CNT_W_DEF,
  parameter int unsigned MIN_PULSES = PWM_MIN_PULSES_DEF,
  parameter int unsigned TIMEOUT    = PWM_TIMEOUT_DEF
) (
  input  logic                                          HCLK,
  input  logic                                          HRESETn,
  input  logic [NUM_CH-1:0]                             pwm,
  input  logic                                          start,
  input  logic [CNT_W-1:0]                              exp_period,
  input  logic [CNT_W-1:0]                              exp_high,
  input  logic [CNT_W-1:0]                              tol,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
  output logic [NUM_CH-1:0]                             done,
  output logic [NUM_CH-1:0]                             pass,
  output logic [NUM_CH-1:0]                             fail,
  output logic                                          all_pass,
  output logic [CNT_W-1:0]                              meas_period,
  output logic [CNT_W-1:0]                              meas_high
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("pwm_monitor: NUM_CH must be in 1..16");
  end

  logic [CNT_W-1:0] ch_period [NUM_CH];
  logic [CNT_W-1:0] ch_high   [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_monitor_ch #(
      .CNT_W      (CNT_W),
      .MIN_PULSES (MIN_PULSES),
      .TIMEOUT    (TIMEOUT)
    ) u_ch (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .pwm         (pwm[i]),
      .start       (start),
      .exp_period  (exp_period),
      .exp_high    (exp_high),
      .tol         (tol),
      .done        (done[i]),
      .pass        (pass[i]),
      .fail        (fail[i]),
      .meas_period (ch_period[i]),
      .meas_high   (ch_high[i])
    );
  end

  assign all_pass = &pass;

  // Out-of-range selects (NUM_CH not a power of two) read back as zero.
  always_comb begin
    meas_period = '0;
    meas_high   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_sel == SEL_W'(i)) begin
        meas_period = ch_period[i];
        meas_high   = ch_high[i];
      end
    end
  end

endmodule
